nmx_wb_arbiter: RTL and testbench

// - Two-master Wishbone arbiter sharing the single slave port of the Neuromorphic_X1_wb CIM macro.
// - M0 = Caravel management host (wbs_*); M1 = on-chip spike/inference sequencer.
// - Round-robin grant, held for a whole cycle (cyc high); only the owner sees slave data and ack.
// - Optional watchdog terminates stalled cycles. Sits between user_project_wrapper and the macro.
//

---
 rtl/nmx_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_nmx_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nmx_wb_arbiter.sv
// nmx_wb_arbiter: round-robin arbiter that lets two Wishbone masters share the
// single slave port of the Neuromorphic_X1_wb CIM macro.
// M0 = management host, M1 = spike/inference sequencer.
// Optional stall watchdog: define NMX_ARB_WATCHDOG_EN to build it in.
module nmx_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  // slave (macro)
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  // status
  output logic [1:0]  grant_o,
  output logic        err_o
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  state_t  state_q, state_d;
  logic    last_q, last_d;   // 1: M1 owned last, so M0 wins the next tie
  wb_req_t req0, req1, own;
  logic    own_act;          // owner has an active strobe inside its cycle
  logic    wd_fire;          // watchdog terminates the current beat
  logic    m_ack;
  logic [31:0] m_dat;

  assign req0 = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
  assign req1 = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

  // State and last-owner registers; reset leaves M1 as last owner.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Arbitration: grant only from IDLE, hold until the owner drops cyc.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: if (!m0_cyc_i) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
      OWN1: if (!m1_cyc_i) begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Route the owner's request to the slave and the slave reply to the owner.
  always_comb begin
    own = '0;
    case (state_q)
      OWN0:    own = req0;
      OWN1:    own = req1;
      default: own = '0;
    endcase
    own_act = own.cyc & own.stb;
    s_cyc_o = own.cyc;
    s_stb_o = own_act & ~wd_fire;
    s_we_o  = own.we;
    s_sel_o = own.sel;
    s_adr_o = own.adr;
    s_dat_o = own.dat;
    // An ack is only forwarded against a live strobe; stray acks are dropped.
    m_ack    = (s_stb_o & s_ack_i) | wd_fire;
    m_dat    = wd_fire ? ERR_DATA : s_dat_i;
    m0_ack_o = (state_q == OWN0) & m_ack;
    m1_ack_o = (state_q == OWN1) & m_ack;
    m0_dat_o = (state_q == OWN0) ? m_dat : 32'h0;
    m1_dat_o = (state_q == OWN1) ? m_dat : 32'h0;
    grant_o  = state_q;
  end

`ifdef NMX_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        err_q;

  assign wd_fire = own_act && (wd_cnt == 16'(TIMEOUT_CYCLES));
  assign err_o   = err_q;

  // Stall counter: counts unacked strobe cycles of the current owner.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      wd_cnt <= 16'h0;
    else if (state_d != state_q || state_q == IDLE || s_ack_i || wd_fire)
      wd_cnt <= 16'h0;
    else if (own_act)
      wd_cnt <= wd_cnt + 16'h1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)     err_q <= 1'b0;
    else if (wd_fire) err_q <= 1'b1;
  end
`else
  // No watchdog: a stalled slave keeps the bus until the owner gives up.
  assign wd_fire = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_nmx_wb_arbiter.sv
// Self-checking bench for nmx_wb_arbiter (reset, single master, tie,
// burst hold, watchdog on/off depending on NMX_ARB_WATCHDOG_EN).
module tb_nmx_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_ack;
  logic [1:0]  grant;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  nmx_wb_arbiter #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant), .err_o(err)
  );

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_adr = 0; m0_dat = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_adr = 0; m1_dat = 0;
    s_ack = 0; s_rdat = 0;
  endtask

  task automatic reset_pulse();
    rst = 1; cyc_step(); rst = 0;
  endtask

  task automatic test_reset();
    idle_all();
    s_ack = 1; s_rdat = 32'h1111_2222;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_scyc got %b exp 0", s_cyc); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    checks++; if (m0_ack !== 1'b0 || m0_rdat !== 32'h0) begin errors++; $display("FAIL rst_m0 ack %b dat %h exp 0/0", m0_ack, m0_rdat); end
    s_ack = 0; rst = 0;
    m0_cyc = 1; m0_stb = 1;
    cyc_step();
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_own0 got %b exp 01", grant); end
    s_ack = 1; rst = 1;   // async reset mid-OWN0
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_mid_scyc got %b exp 0", s_cyc); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_mid_grant got %b exp 00", grant); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got %b exp 0", m0_ack); end
    cyc_step();
    rst = 0; idle_all();
    cyc_step();
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_after got %b exp 00", grant); end
  endtask

  task automatic test_single_write();
    s_ack = 1;   // stray ack in IDLE must not be forwarded
    #1;
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL stray_ack got %b%b exp 00", m0_ack, m1_ack); end
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_adr = 32'h3000_0004; m0_dat = 32'h1234_5678;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL sw_latency got %b exp 0", s_cyc); end
    cyc_step();
    #1;
    checks++; if (s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1) begin errors++; $display("FAIL sw_ctl got %b%b%b exp 111", s_cyc, s_stb, s_we); end
    checks++; if (s_adr !== 32'h3000_0004) begin errors++; $display("FAIL sw_adr got %h exp 30000004", s_adr); end
    checks++; if (s_wdat !== 32'h1234_5678 || s_sel !== 4'hF) begin errors++; $display("FAIL sw_dat got %h/%h exp 12345678/f", s_wdat, s_sel); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL sw_noack got %b exp 0", m0_ack); end
    s_ack = 1;
    #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL sw_ack got %b exp 1", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL sw_m1ack got %b exp 0", m1_ack); end
    cyc_step();
    idle_all();
    cyc_step();
    #1;
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin errors++; $display("FAIL sw_release grant %b scyc %b exp 00/0", grant, s_cyc); end
  endtask

  task automatic test_tie();
    reset_pulse();
    idle_all();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    cyc_step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie1_first got %b exp 01", grant); end
    m0_cyc = 0; m0_stb = 0;
    cyc_step(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie1_gap got %b exp 00", grant); end
    cyc_step(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie1_second got %b exp 10", grant); end
    m1_cyc = 0; m1_stb = 0;
    cyc_step(); #1;
    // last owner now M1 -> M0 wins
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    cyc_step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie2 got %b exp 01", grant); end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    cyc_step(); #1;
    // last owner now M0 -> M1 wins
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    cyc_step(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie3 got %b exp 10", grant); end
    idle_all();
    cyc_step();
  endtask

  task automatic test_burst_hold();
    reset_pulse();
    idle_all();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h3000_0010;
    cyc_step(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_grant got %b exp 10", grant); end
    m0_cyc = 1; m0_stb = 1;
    for (int k = 1; k <= 4; k++) begin
      s_rdat = 32'hA5A5_0000 + k;
      s_ack  = 1;
      exp_q.push_back(32'hA5A5_0000 + k);
      #1;
      checks++;
      if (m1_ack !== 1'b1) begin
        errors++; $display("FAIL burst_ack%0d got %b exp 1", k, m1_ack);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (m1_rdat !== e) begin errors++; $display("FAIL burst_dat%0d got %h exp %h", k, m1_rdat, e); end
      end
      checks++; if (m0_ack !== 1'b0 || m0_rdat !== 32'h0) begin errors++; $display("FAIL burst_m0_%0d ack %b dat %h exp 0/0", k, m0_ack, m0_rdat); end
      cyc_step();
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0; s_rdat = 0;
    #1;
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL burst_rel_m0 got %b exp 0", m0_ack); end
    cyc_step(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_gap got %b exp 00", grant); end
    cyc_step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_m0_grant got %b exp 01", grant); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_queue left %0d exp 0", exp_q.size()); end
    idle_all();
    cyc_step();
  endtask

`ifdef NMX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    logic early;
    early = 0;
    reset_pulse();
    idle_all();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h3000_0020;
    cyc_step();
    for (int i = 0; i < 16; i++) begin
      #1;
      if (m0_ack !== 1'b0) early = 1;
      cyc_step();
    end
    checks++; if (early) begin errors++; $display("FAIL wd_early got ack exp none"); end
    #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL wd_ack got %b exp 1", m0_ack); end
    checks++; if (m0_rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wd_dat got %h exp deadbeef", m0_rdat); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL wd_stb got %b exp 0", s_stb); end
    cyc_step(); #1;
    checks++; if (err !== 1'b1 || m0_ack !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL wd_after err %b ack %b grant %b exp 1/0/01", err, m0_ack, grant); end
    idle_all();
    cyc_step(); cyc_step(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp 1", err); end
  endtask
`else
  task automatic test_no_watchdog();
    logic seen;
    seen = 0;
    reset_pulse();
    idle_all();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h3000_0020;
    cyc_step();
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (m0_ack !== 1'b0 || err !== 1'b0) seen = 1;
      cyc_step();
    end
    checks++; if (seen) begin errors++; $display("FAIL nowd_ack saw ack/err exp none"); end
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL nowd_grant got %b exp 01", grant); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL nowd_err got %b exp 0", err); end
    idle_all();
    cyc_step();
  endtask
`endif

  initial begin
    idle_all();
    test_reset();
    test_single_write();
    test_tie();
    test_burst_hold();
`ifdef NMX_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
